// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide, one bit per cycle, using the ALU's shared adder.
// Latency: done 35 cycles after start (2 for fast special cases); o_busy stalls the pipe, starts while busy are ignored.
module cpu_muldiv #(
  parameter bit p_fast_special = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_kill,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [33:0] i_adder_fout,
  output logic        o_use_md,
  output logic [32:0] o_op_a_md,
  output logic [32:0] o_op_b_md,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state;
  logic [2:0]  op;
  logic [31:0] hi;   // product high word / remainder
  logic [31:0] lo;   // product low word / quotient; holds raw rs1 until INIT
  logic [31:0] dv;   // multiplicand / divisor; holds raw rs2 until INIT
  logic [4:0]  cnt;
  logic        neg;

  logic        is_div, a_signed, b_signed, sa, sb, div_zero, ovf, ge;
  logic [31:0] mag_a, mag_b, special_res, quo_n, rem_n, fix_res;
  logic [32:0] trial;
  logic [63:0] prod_n;
  logic        unused_fout_lsb;

  assign unused_fout_lsb = i_adder_fout[0];

  always_comb begin
    is_div      = op[2];
    a_signed    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    sa          = a_signed & lo[31];
    sb          = b_signed & dv[31];
    mag_a       = sa ? (32'd0 - lo) : lo;
    mag_b       = sb ? (32'd0 - dv) : dv;
    div_zero    = is_div && (dv == 32'd0);
    ovf         = is_div && !op[0] && (lo == 32'h8000_0000) && (dv == 32'hFFFF_FFFF);
    special_res = div_zero ? (op[1] ? lo : 32'hFFFF_FFFF)
                           : (op[1] ? 32'd0 : 32'h8000_0000);

    trial = {hi, lo[31]};
    ge    = i_adder_fout[33] | trial[32];

    prod_n = neg ? (64'd0 - {hi, lo}) : {hi, lo};
    quo_n  = neg ? (32'd0 - lo) : lo;
    rem_n  = neg ? (32'd0 - hi) : hi;
    case (op)
      3'd0:       fix_res = prod_n[31:0];
      3'd4, 3'd5: fix_res = quo_n;
      3'd6, 3'd7: fix_res = rem_n;
      default:    fix_res = prod_n[63:32];
    endcase

    o_op_a_md = 33'd0;
    o_op_b_md = 33'd0;
    if (state == S_CALC) begin
      if (is_div) begin
        o_op_a_md = {trial[31:0], 1'b1};
        o_op_b_md = {~dv, 1'b1};
      end else begin
        o_op_a_md = {hi, 1'b0};
        o_op_b_md = lo[0] ? {dv, 1'b0} : 33'd0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      op       <= 3'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      dv       <= 32'd0;
      cnt      <= 5'd0;
      neg      <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_use_md <= 1'b0;
      o_result <= 32'd0;
    end else if (i_kill) begin
      state    <= S_IDLE;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_use_md <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            op     <= i_op;
            lo     <= i_rs1;
            dv     <= i_rs2;
            o_busy <= 1'b1;
            state  <= S_INIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_INIT: begin
          hi  <= 32'd0;
          cnt <= 5'd0;
          // A zero divisor leaves an all-ones quotient that must not be negated.
          neg <= (is_div && op[1]) ? sa : ((sa ^ sb) & ~div_zero);
          lo  <= is_div ? mag_a : mag_b;
          dv  <= is_div ? mag_b : mag_a;
          if (p_fast_special && (div_zero || ovf)) begin
            o_result <= special_res;
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            state    <= S_DONE;
          end else begin
            o_use_md <= 1'b1;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (is_div) begin
            hi <= ge ? i_adder_fout[32:1] : trial[31:0];
            lo <= {lo[30:0], ge};
          end else begin
            hi <= i_adder_fout[33:2];
            lo <= {i_adder_fout[1], lo[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            o_use_md <= 1'b0;
            state    <= S_FIX;
          end
        end
        S_FIX: begin
          o_result <= fix_res;
          o_done   <= 1'b1;
          o_busy   <= 1'b0;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
